// File: rtl/i2c_target_regs_if.sv
// Bus-side and register-file-side signals of the I2C register target.
// The slave modport is the target's view; the master modport is the view
// of whatever drives the pads and hosts the register file.
interface i2c_target_regs_if #(
    parameter int unsigned PTR_W  = 4,
    parameter int unsigned DATA_W = 8
);
    logic              scl_in;
    logic              sda_in;
    logic              sda_oe;
    logic              wr_valid;
    logic [PTR_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [PTR_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    modport slave (
        input  scl_in,
        input  sda_in,
        input  rd_data,
        output sda_oe,
        output wr_valid,
        output wr_addr,
        output wr_data,
        output rd_addr,
        output busy
    );

    modport master (
        output scl_in,
        output sda_in,
        output rd_data,
        input  sda_oe,
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        input  busy
    );
endinterface

// File: rtl/i2c_target_regs.sv
// Oversampled I2C target with a register pointer and burst read/write.
// SCL and SDA are sampled on clk; every bus event is derived from the
// synchronised lines, so nothing here is clocked by the bus.
module i2c_target_regs #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h55,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned PTR_W      = 4,
    parameter int unsigned DATA_W     = 8
) (
    input logic              clk,
    input logic              rst,
    i2c_target_regs_if.slave bus
);

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck,
        StWait
    } state_e;

    // Synchroniser and edge-history flops.
    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    logic scl_rise, scl_fall, start_det, stop_det;

    state_e            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shreg_q, shreg_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              ack_drv_q, ack_drv_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              wr_valid_q, wr_valid_d;
    logic [PTR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [7:0]        rx_byte;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_load;
    logic [2:0]        rd_idx;

    // Two-flop synchronisers plus one history flop; idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_s1 <= bus.scl_in;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= bus.sda_in;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;

    // Byte as it stands once the current rising-edge bit is shifted in.
    assign rx_byte  = {shreg_q, sda_s2};
    assign ptr_inc  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);
    assign ptr_load = PTR_W'(32'(rx_byte[PTR_W-1:0]) % NUM_REGS);
    assign rd_idx   = 3'(bit_cnt_q - 4'd1);

    // State and datapath registers; reset drops SDA asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= 7'd0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            ack_drv_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            ack_drv_q  <= ack_drv_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Next-state logic; START/STOP take priority over every state.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        ack_drv_d  = ack_drv_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (stop_det) begin
            state_d   = StIdle;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            ack_drv_d = 1'b0;
        end else if (start_det) begin
            // Pointer is kept so a restart can read back from it.
            state_d   = StAddr;
            bit_cnt_d = 4'd7;
            sda_oe_d  = 1'b0;
            ack_drv_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;

                StAddr: begin
                    if (scl_rise) begin
                        shreg_d = rx_byte[6:0];
                        if (bit_cnt_q == 4'd0) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state_d = StAddrAck;
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                            end else begin
                                state_d = StWait;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 4'd1;
                        end
                    end
                end

                // First falling edge pulls the ACK, the second one releases it.
                StAddrAck, StPtrAck, StWdataAck: begin
                    if (scl_fall) begin
                        if (!ack_drv_q) begin
                            sda_oe_d  = 1'b1;
                            ack_drv_d = 1'b1;
                        end else begin
                            ack_drv_d = 1'b0;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd7;
                            if (state_q == StAddrAck && rw_q) begin
                                state_d  = StRdata;
                                sda_oe_d = ~bus.rd_data[DATA_W-1];
                            end else if (state_q == StAddrAck) begin
                                state_d = StPtr;
                            end else begin
                                state_d = StWdata;
                            end
                        end
                    end
                end

                StPtr: begin
                    if (scl_rise) begin
                        shreg_d = rx_byte[6:0];
                        if (bit_cnt_q == 4'd0) begin
                            ptr_d   = ptr_load;
                            state_d = StPtrAck;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 4'd1;
                        end
                    end
                end

                StWdata: begin
                    if (scl_rise) begin
                        shreg_d = rx_byte[6:0];
                        if (bit_cnt_q == 4'd0) begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = DATA_W'(rx_byte);
                            ptr_d      = ptr_inc;
                            state_d    = StWdataAck;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 4'd1;
                        end
                    end
                end

                // bit_cnt counts bits still to drive; 0 means the byte is out.
                StRdata: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = StRdataAck;
                        end else begin
                            sda_oe_d  = ~bus.rd_data[rd_idx];
                            bit_cnt_d = bit_cnt_q - 4'd1;
                        end
                    end
                end

                // Pointer moves past every byte sent, whether acked or not.
                StRdataAck: begin
                    if (scl_rise) begin
                        ptr_d = ptr_inc;
                        if (!sda_s2) begin
                            state_d   = StRdata;
                            bit_cnt_d = 4'd8;
                        end else begin
                            state_d = StWait;
                            busy_d  = 1'b0;
                        end
                    end
                end

                StWait: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.busy     = busy_q;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.rd_addr  = ptr_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C master driven from a table
// of bus operations, plus hand-written abort and reset sequences.
module tb_i2c_target_regs;

    localparam int Q = 4; // clk cycles per quarter SCL period

    typedef enum logic [1:0] {OpStart, OpStop, OpWr, OpRd} op_e;

    typedef struct {
        op_e        op;
        logic [7:0] dat;      // byte to write (OpWr)
        logic       mack;     // master ACK bit after a read (OpRd)
        logic [7:0] exp;      // OpWr: expected ACK bit in [0]; OpRd: expected byte
        logic       exp_busy;
        logic       exp_oe;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic scl;
    logic sda_m;

    always #5 clk = ~clk;

    i2c_target_regs_if #(.PTR_W(4), .DATA_W(8)) bif ();

    assign bif.scl_in  = scl;
    assign bif.sda_in  = sda_m & ~bif.sda_oe;
    assign bif.rd_data = 8'h40 + {4'h0, bif.rd_addr};

    i2c_target_regs #(
        .SLAVE_ADDR(7'h55),
        .NUM_REGS  (16),
        .PTR_W     (4),
        .DATA_W    (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] wr_log[$];
    int unsigned oe_cnt = 0;
    vec_t        vt[20];

    // Record write strobes and any SDA pull-down.
    always @(negedge clk) begin
        if (bif.wr_valid) wr_log.push_back({bif.wr_addr, bif.wr_data});
        if (bif.sda_oe) oe_cnt <= oe_cnt + 1;
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        sda_m = b;    wait_q();
        scl   = 1'b1; wait_q();
        s = bif.sda_in;
        wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(mack, s);
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        logic       ack;
        logic [7:0] rb;
        for (int i = lo; i <= hi; i++) begin
            case (vt[i].op)
                OpStart: bus_start();
                OpStop:  bus_stop();
                OpWr: begin
                    wr_byte(vt[i].dat, ack);
                    check($sformatf("v%0d ack", i), ack, vt[i].exp[0]);
                end
                OpRd: begin
                    rd_byte(vt[i].mack, rb);
                    check($sformatf("v%0d rdata", i), rb, vt[i].exp);
                end
                default: ;
            endcase
            check($sformatf("v%0d busy", i), bif.busy, vt[i].exp_busy);
            check($sformatf("v%0d sda_oe", i), bif.sda_oe, vt[i].exp_oe);
        end
    endtask

    initial begin
        logic [11:0] exp_wr[3];
        logic        ack;
        logic        s;
        int          base;
        int unsigned oe0;

        // Write burst with pointer wrap.
        vt[0]  = '{OpStart, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[1]  = '{OpWr,    8'hAA, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2]  = '{OpWr,    8'h0E, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[3]  = '{OpWr,    8'h11, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[4]  = '{OpWr,    8'h22, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[5]  = '{OpWr,    8'h33, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[6]  = '{OpStop,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        // Address mismatch: no ACK anywhere.
        vt[7]  = '{OpStart, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[8]  = '{OpWr,    8'hA8, 1'b0, 8'h01, 1'b0, 1'b0};
        vt[9]  = '{OpWr,    8'h99, 1'b0, 8'h01, 1'b0, 1'b0};
        vt[10] = '{OpStop,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        // Pointer write, repeated START, burst read of 0x43..0x45.
        vt[11] = '{OpStart, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[12] = '{OpWr,    8'hAA, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[13] = '{OpWr,    8'h03, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[14] = '{OpStart, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[15] = '{OpWr,    8'hAB, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[16] = '{OpRd,    8'h00, 1'b0, 8'h43, 1'b1, 1'b1};
        vt[17] = '{OpRd,    8'h00, 1'b0, 8'h44, 1'b1, 1'b1};
        vt[18] = '{OpRd,    8'h00, 1'b1, 8'h45, 1'b0, 1'b0};
        vt[19] = '{OpStop,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        exp_wr[0] = 12'hE11;
        exp_wr[1] = 12'hF22;
        exp_wr[2] = 12'h033;

        rst   = 1'b1;
        scl   = 1'b1;
        sda_m = 1'b1;
        repeat (3) @(negedge clk);
        check("reset sda_oe", bif.sda_oe, 1'b0);
        check("reset busy", bif.busy, 1'b0);
        check("reset wr_valid", bif.wr_valid, 1'b0);
        check("reset rd_addr", bif.rd_addr, 4'h0);
        check("reset wr_addr", bif.wr_addr, 4'h0);
        check("reset wr_data", bif.wr_data, 8'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        apply_vecs(0, 6);
        check("burst wr count", wr_log.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("burst wr%0d", i), (i < wr_log.size()) ? wr_log[i] : 12'hFFF,
                  exp_wr[i]);
        check("burst rd_addr", bif.rd_addr, 4'h1);

        oe0 = oe_cnt;
        apply_vecs(7, 10);
        check("mismatch oe pulls", oe_cnt - oe0, 0);
        check("mismatch wr count", wr_log.size(), 3);

        apply_vecs(11, 19);
        check("read rd_addr", bif.rd_addr, 4'h6);
        check("read wr count", wr_log.size(), 3);

        // Abort in the middle of a data byte.
        base = wr_log.size();
        bus_start();
        wr_byte(8'hAA, ack); check("abort addr ack", ack, 1'b0);
        wr_byte(8'h02, ack); check("abort ptr ack", ack, 1'b0);
        bit_xfer(1'b1, s); bit_xfer(1'b0, s); bit_xfer(1'b1, s); bit_xfer(1'b0, s);
        bus_stop();
        check("abort wr count", wr_log.size(), base);
        check("abort busy", bif.busy, 1'b0);
        check("abort sda_oe", bif.sda_oe, 1'b0);
        check("abort rd_addr", bif.rd_addr, 4'h2);
        bus_start();
        wr_byte(8'hAA, ack); check("post-abort addr ack", ack, 1'b0);
        wr_byte(8'h05, ack); check("post-abort ptr ack", ack, 1'b0);
        wr_byte(8'h5A, ack); check("post-abort data ack", ack, 1'b0);
        bus_stop();
        check("post-abort wr count", wr_log.size(), base + 1);
        check("post-abort wr", (wr_log.size() > base) ? wr_log[base] : 12'hFFF, 12'h55A);
        check("post-abort rd_addr", bif.rd_addr, 4'h6);

        // Reset while the target drives bit 7 (a 0) of reg 1 = 0x41.
        bus_start();
        wr_byte(8'hAA, ack); check("rst addr ack", ack, 1'b0);
        wr_byte(8'h01, ack); check("rst ptr ack", ack, 1'b0);
        bus_start();
        wr_byte(8'hAB, ack); check("rst raddr ack", ack, 1'b0);
        check("rst pre sda_oe", bif.sda_oe, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst sda_oe", bif.sda_oe, 1'b0);
        check("rst busy", bif.busy, 1'b0);
        check("rst wr_valid", bif.wr_valid, 1'b0);
        check("rst wr_addr", bif.wr_addr, 4'h0);
        check("rst wr_data", bif.wr_data, 8'h00);
        check("rst rd_addr", bif.rd_addr, 4'h0);
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        sda_m = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        bus_start();
        wr_byte(8'hAA, ack); check("post-rst addr ack", ack, 1'b0);
        check("post-rst busy", bif.busy, 1'b1);
        wr_byte(8'h07, ack); check("post-rst ptr ack", ack, 1'b0);
        bus_stop();
        check("post-rst rd_addr", bif.rd_addr, 4'h7);
        check("post-rst busy end", bif.busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
